// File: rtl/blink_pkg.sv
// Shared mode type and phase-0 helpers for the multi-channel LED blink controller.
// Each channel decides its load-edge LED and done values through these helpers.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // LED value on the edge a configuration is accepted (counter at phase 0).
    function automatic logic phase0_led(
        input mode_t mode,
        input logic  high_nz,
        input logic  period_nz
    );
        case (mode)
            MODE_OFF: return 1'b0;
            MODE_ON:  return 1'b1;
            default:  return high_nz && period_nz;
        endcase
    endfunction

    // A burst with nothing to emit completes on the load edge itself.
    function automatic logic burst_empty(
        input mode_t mode,
        input logic  count_nz,
        input logic  period_nz
    );
        return (mode == MODE_BURST) && (!count_nz || !period_nz);
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: latched configuration, phase and burst counters, registered led/done.
// Load has priority over any counting activity on the same edge.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W   = 27,
    parameter int BURST_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  mode_t              cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_count,
    output logic               led,
    output logic               done
);

    mode_t              mode, mode_next;
    logic [CNT_W-1:0]   period, period_next;
    logic [CNT_W-1:0]   high, high_next;
    logic [CNT_W-1:0]   phase, phase_next;
    logic [BURST_W-1:0] count, count_next;
    logic [BURST_W-1:0] bursts, bursts_next;
    logic               led_next, done_next;
    logic               wrap;
    logic               running;
    logic [CNT_W-1:0]   phase_inc;
    logic [BURST_W-1:0] bursts_inc;

    always_comb begin
        mode_next   = mode;
        period_next = period;
        high_next   = high;
        count_next  = count;
        phase_next  = phase;
        bursts_next = bursts;
        led_next    = led;
        done_next   = done;
        wrap        = 1'b0;
        phase_inc   = phase + CNT_W'(1);
        bursts_inc  = bursts + BURST_W'(1);
        running     = (mode == MODE_BLINK) || ((mode == MODE_BURST) && !done);

        if (load) begin
            mode_next   = cfg_mode;
            period_next = cfg_period;
            high_next   = cfg_high;
            count_next  = cfg_count;
            phase_next  = '0;
            bursts_next = '0;
            led_next    = phase0_led(cfg_mode, cfg_high != '0, cfg_period != '0);
            done_next   = 1'b0;
            if (burst_empty(cfg_mode, cfg_count != '0, cfg_period != '0)) begin
                led_next  = 1'b0;
                done_next = 1'b1;
            end
        end else if (running) begin
            if (period == '0) begin
                phase_next = '0;
                led_next   = 1'b0;
            end else begin
                wrap       = (phase == period - CNT_W'(1));
                phase_next = wrap ? '0 : phase_inc;
                led_next   = (phase_next < high);
                // Final wrap of a burst parks the channel dark with done raised.
                if ((mode == MODE_BURST) && wrap) begin
                    bursts_next = bursts_inc;
                    if (bursts_inc == count) begin
                        led_next  = 1'b0;
                        done_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode   <= MODE_OFF;
            period <= '0;
            high   <= '0;
            count  <= '0;
            phase  <= '0;
            bursts <= '0;
            led    <= 1'b0;
            done   <= 1'b0;
        end else begin
            mode   <= mode_next;
            period <= period_next;
            high   <= high_next;
            count  <= count_next;
            phase  <= phase_next;
            bursts <= bursts_next;
            led    <= led_next;
            done   <= done_next;
        end
    end

endmodule

// File: rtl/blink_controller.sv
// Multi-channel LED blink controller: decodes configuration requests into
// per-channel load strobes and gathers the channel led/done outputs.
module blink_controller
    import blink_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  CNT_W    = 27,
    parameter int  BURST_W  = 8,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [BURST_W-1:0]  cfg_count,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] done
);

    logic  accept;
    mode_t mode_in;

    // Ready tracks the previous edge's reset_n, so the release edge never accepts.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    assign accept  = cfg_valid && cfg_ready;
    assign mode_in = mode_t'(cfg_mode);

    // Out-of-range channel numbers match no strobe and are dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic load;

        assign load = accept && (cfg_chan == CHAN_W'(g));

        blink_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_channel (
            .clock      (clock),
            .reset_n    (reset_n),
            .load       (load),
            .cfg_mode   (mode_in),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .cfg_count  (cfg_count),
            .led        (led[g]),
            .done       (done[g])
        );
    end

endmodule

// File: tb/tb_blink_controller.sv
// Scenario bench for blink_controller: each task builds a stimulus table, queues the
// expected led/done/ready per edge, then drives and checks edge by edge.
module tb_blink_controller;
    import blink_pkg::*;

    localparam int CHANNELS = 3;
    localparam int CNT_W    = 8;
    localparam int BURST_W  = 4;
    localparam int CHAN_W   = 2;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CHAN_W-1:0]   cfg_chan;
    logic [1:0]          cfg_mode;
    logic [CNT_W-1:0]    cfg_period;
    logic [CNT_W-1:0]    cfg_high;
    logic [BURST_W-1:0]  cfg_count;
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] done;

    typedef struct {
        logic                rst;
        logic                valid;
        logic [CHAN_W-1:0]   chan;
        logic [1:0]          mode;
        logic [CNT_W-1:0]    period;
        logic [CNT_W-1:0]    high;
        logic [BURST_W-1:0]  count;
        logic [CHANNELS-1:0] led;
        logic [CHANNELS-1:0] done;
        logic                ready;
    } step_t;

    typedef struct {
        string               tag;
        logic [CHANNELS-1:0] led;
        logic [CHANNELS-1:0] done;
        logic                ready;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    blink_controller #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .BURST_W  (BURST_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_count  (cfg_count),
        .led        (led),
        .done       (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required finish before 200000 time units");
        $fatal(1);
    end

    function automatic step_t mk(int rst, int valid, int chan, int mode, int period,
                                 int high, int count, int led_e, int done_e, int ready);
        step_t s;
        s.rst    = rst[0];
        s.valid  = valid[0];
        s.chan   = CHAN_W'(chan);
        s.mode   = 2'(mode);
        s.period = CNT_W'(period);
        s.high   = CNT_W'(high);
        s.count  = BURST_W'(count);
        s.led    = CHANNELS'(led_e);
        s.done   = CHANNELS'(done_e);
        s.ready  = ready[0];
        return s;
    endfunction

    function automatic void sb_push(string tag, step_t s);
        exp_t e;
        e.tag   = tag;
        e.led   = s.led;
        e.done  = s.done;
        e.ready = s.ready;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(step_t s);
        reset_n    = s.rst;
        cfg_valid  = s.valid;
        cfg_chan   = s.chan;
        cfg_mode   = s.mode;
        cfg_period = s.period;
        cfg_high   = s.high;
        cfg_count  = s.count;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 1, 0, MODE_ON, 0, 0, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(1, 1, 0, MODE_ON, 0, 0, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(1, 1, 0, MODE_ON, 0, 0, 0, 3'b001, 3'b000, 1));
        tbl.push_back(mk(1, 1, 0, MODE_OFF, 0, 0, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, 3'b000, 3'b000, 1));
        foreach (tbl[i]) sb_push($sformatf("reset[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_blink();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 12; k++)
            tbl.push_back(mk(1, k == 0, 0, MODE_BLINK, 4, 1, 0,
                             (k % 4 == 0) ? 3'b001 : 3'b000, 3'b000, 1));
        foreach (tbl[i]) sb_push($sformatf("blink[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_burst();
        step_t tbl[$];
        exp_t  e;
        int    pat[10] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, k == 0, 1, MODE_BURST, 3, 2, 2,
                             pat[k] << 1, (k >= 6) ? 3'b010 : 3'b000, 1));
        foreach (tbl[i]) sb_push($sformatf("burst[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_boundaries();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        // high == period: constantly lit
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, k == 0, 0, MODE_BLINK, 5, 5, 0, 3'b001, 3'b000, 1));
        // period 0: dark
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, k == 0, 0, MODE_BLINK, 0, 3, 0, 3'b000, 3'b000, 1));
        // burst with count 0 completes on the accept edge
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, k == 0, 2, MODE_BURST, 4, 2, 0, 3'b000, 3'b100, 1));
        // channel number out of range is ignored
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1, 1, 3, MODE_ON, 4, 2, 1, 3'b000, 3'b100, 1));
        // period 1: counter pinned at 0, lit while high >= 1
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, k == 0, 1, MODE_BLINK, 1, 1, 0, 3'b010, 3'b100, 1));
        // burst with period 0 completes immediately
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1, k == 0, 0, MODE_BURST, 0, 3, 5, 3'b010, 3'b101, 1));
        foreach (tbl[i]) sb_push($sformatf("boundary[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_reconfig();
        step_t tbl[$];
        exp_t  e;
        int    l0, l2;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            l0 = (k % 4 == 0) ? 1 : 0;
            if (k == 0)      l2 = 0;
            else if (k < 5)  l2 = 1;
            else if (k < 8)  l2 = 0;
            else             l2 = ((k - 8) % 2 == 0) ? 1 : 0;
            if (k == 0)
                tbl.push_back(mk(1, 1, 0, MODE_BLINK, 4, 1, 0, (l2 << 2) | l0, 0, 1));
            else if (k == 1)
                tbl.push_back(mk(1, 1, 2, MODE_BLINK, 8, 4, 0, (l2 << 2) | l0, 0, 1));
            else if (k == 8)
                tbl.push_back(mk(1, 1, 2, MODE_BLINK, 2, 1, 0, (l2 << 2) | l0, 0, 1));
            else
                tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, (l2 << 2) | l0, 0, 1));
        end
        foreach (tbl[i]) sb_push($sformatf("reconfig[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_reset_burst();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back(mk(1, 1, 1, MODE_BURST, 6, 3, 3, 3'b010, 3'b000, 1));
        tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, 3'b010, 3'b000, 1));
        tbl.push_back(mk(0, 0, 0, MODE_OFF, 0, 0, 0, 3'b000, 3'b000, 0));
        for (int k = 3; k < 10; k++)
            tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(1, 1, 1, MODE_BLINK, 2, 1, 0, 3'b010, 3'b000, 1));
        tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, 3'b010, 3'b000, 1));
        foreach (tbl[i]) sb_push($sformatf("reset_burst[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    task automatic test_simultaneous();
        step_t tbl[$];
        exp_t  e;
        int    pat[12] = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 0)
                tbl.push_back(mk(1, 1, 1, MODE_BURST, 3, 2, 2, pat[k] << 1, 0, 1));
            else if (k == 6)
                tbl.push_back(mk(1, 1, 1, MODE_BLINK, 4, 1, 0, pat[k] << 1, 0, 1));
            else
                tbl.push_back(mk(1, 0, 0, MODE_OFF, 0, 0, 0, pat[k] << 1, 0, 1));
        end
        foreach (tbl[i]) sb_push($sformatf("simultaneous[%0d]", i), tbl[i]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            e = sb.pop_front();
            total++;
            if ({led, done, cfg_ready} !== {e.led, e.done, e.ready}) begin
                bad++;
                $display("FAIL %s: got led=%b done=%b ready=%b, required led=%b done=%b ready=%b",
                         e.tag, led, done, cfg_ready, e.led, e.done, e.ready);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_count  = '0;
        test_reset();
        test_blink();
        test_burst();
        test_boundaries();
        test_reconfig();
        test_reset_burst();
        test_simultaneous();
        cfg_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
